// File: rtl/neo_pkg.sv
// Shared types and helpers for the move scheduler: direction encoding, scheduler states,
// and the fixed-priority request arbitration used on the debounced direction pulses.
package neo_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_ISSUE      = 2'd2,
        S_BUSY       = 2'd3
    } sched_state_e;

    localparam int DROP_CNT_W = 8;

    // Lowest set bit wins: up > down > left > right.
    function automatic dir_e lowest_dir(input logic [3:0] req);
        dir_e d;
        casez (req)
            4'b???1: d = DIR_UP;
            4'b??10: d = DIR_DOWN;
            4'b?100: d = DIR_LEFT;
            default: d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    function automatic logic multi_req(input logic [3:0] req);
        return |(req & (req - 4'd1));
    endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: small synchronous FIFO of pending directions with push/pop/flush.
// Push is refused when full and pop when empty, judged on the level at the start of the cycle.
module move_fifo
    import neo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  dir_e                        push_dir,
    input  logic                        pop,
    input  logic                        flush,
    output dir_e                        head,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    dir_e           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the start-of-cycle level.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // NOTE: storage is not reset; the level counter alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dir;
    end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates direction pulses into a move FIFO and hands moves to the game
// engine one at a time. Define MOVE_SCHED_FRAME_SYNC_EN to hold each issue for frame_start.
module move_scheduler
    import neo_pkg::*;
#(
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   dir_req,
    input  logic                         game_over,
    input  logic                         frame_start,
    output logic                         mv_valid,
    output dir_e                         mv_dir,
    input  logic                         mv_ready,
    input  logic                         eng_done,
    output logic                         busy,
    output logic                         timeout,
    output logic [$clog2(QDEPTH+1)-1:0]  q_level,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);
    localparam int            TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    sched_state_e   state;
    sched_state_e   state_next;
    logic [TW-1:0]  timer;
    dir_e           fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           req_valid;
    logic           req_drop;
    logic           handshake;
    logic           load_dir;
    logic           timeout_hit;

    assign req_valid = (dir_req != 4'd0) && !game_over;
    assign req_drop  = req_valid && (multi_req(dir_req) || fifo_full);
    assign handshake = (state == S_ISSUE) && mv_ready;

    move_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_valid),
        .push_dir (lowest_dir(dir_req)),
        .pop      (handshake),
        .flush    (game_over),
        .head     (fifo_head),
        .level    (q_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifndef MOVE_SCHED_FRAME_SYNC_EN
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value unassigned.
        state_next  = state;
        load_dir    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && !game_over) begin
`ifdef MOVE_SCHED_FRAME_SYNC_EN
                    state_next = S_WAIT_FRAME;
`else
                    state_next = S_ISSUE;
                    load_dir   = 1'b1;
`endif
                end
            end
            S_WAIT_FRAME: begin
`ifdef MOVE_SCHED_FRAME_SYNC_EN
                if (game_over) begin
                    state_next = S_IDLE;
                end else if (frame_start) begin
                    state_next = S_ISSUE;
                    load_dir   = 1'b1;
                end
`else
                state_next = S_IDLE;
`endif
            end
            // The offered move is latched into mv_dir, so a flush cannot disturb it.
            S_ISSUE: begin
                if (mv_ready) state_next = S_BUSY;
            end
            S_BUSY: begin
                if (eng_done) begin
                    state_next = S_IDLE;
                end else if (timer == TIMER_LAST) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            mv_dir   <= DIR_UP;
            drop_cnt <= '0;
        end else begin
            state <= state_next;
            timer <= (state == S_BUSY) ? timer + 1'b1 : '0;
            if (load_dir) mv_dir <= fifo_head;
            if (req_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign mv_valid = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);
    // Suppressed while reset is applied so an abandoned move never reports a timeout.
    assign timeout  = reset && timeout_hit;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_move_scheduler;

    localparam int QD = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dir_req;
    logic       game_over;
    logic       frame_start;
    logic       mv_valid;
    logic [1:0] mv_dir;
    logic       mv_ready;
    logic       eng_done;
    logic       busy;
    logic       timeout;
    logic [2:0] q_level;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    move_scheduler #(.QDEPTH(QD), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .dir_req     (dir_req),
        .game_over   (game_over),
        .frame_start (frame_start),
        .mv_valid    (mv_valid),
        .mv_dir      (mv_dir),
        .mv_ready    (mv_ready),
        .eng_done    (eng_done),
        .busy        (busy),
        .timeout     (timeout),
        .q_level     (q_level),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending moves as a queue; the scheduler is described by what it is doing with them.
    int m_q[$];
    bit m_offer   = 1'b0;   // a move is being offered to the engine
    int m_dir     = 0;
    bit m_eng     = 1'b0;   // engine is working on an accepted move
    int m_age     = 0;      // cycles the engine has held the current move
    bit m_wait    = 1'b0;   // holding for the next frame boundary
    int m_drops   = 0;
    bit model_ok  = 1'b0;

    function automatic int first_dir(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int sz;
        bit idle0;
        bit wait0;
        bit acc;
        if (!reset) begin
            m_q.delete();
            m_offer  = 1'b0;
            m_eng    = 1'b0;
            m_wait   = 1'b0;
            m_age    = 0;
            m_drops  = 0;
            m_dir    = 0;
            model_ok = 1'b1;
        end else begin
            sz    = m_q.size();
            idle0 = !(m_offer || m_eng || m_wait);
            wait0 = m_wait;
            acc   = m_offer && mv_ready;
            if (m_eng) begin
                if (eng_done || m_age == TO - 1) m_eng = 1'b0;
                else m_age++;
            end
            if (acc) begin
                m_offer = 1'b0;
                m_eng   = 1'b1;
                m_age   = 0;
            end
            if (idle0 && sz > 0 && !game_over) begin
`ifdef MOVE_SCHED_FRAME_SYNC_EN
                m_wait = 1'b1;
`else
                m_offer = 1'b1;
                m_dir   = m_q[0];
`endif
            end
            if (wait0) begin
                if (game_over) m_wait = 1'b0;
                else if (frame_start) begin
                    m_wait  = 1'b0;
                    m_offer = 1'b1;
                    m_dir   = m_q[0];
                end
            end
            if (game_over) begin
                m_q.delete();
            end else begin
                if (acc && m_q.size() > 0) void'(m_q.pop_front());
                if (dir_req != 4'd0) begin
                    if (sz < QD) m_q.push_back(first_dir(dir_req));
                    if ($countones(dir_req) > 1 || sz == QD)
                        if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_to;
        if (model_ok) begin
            exp_to = reset && m_eng && (m_age == TO - 1) && !eng_done;
            check("m_mv_valid", 32'(mv_valid), 32'(m_offer));
            check("m_busy", 32'(busy), 32'(m_offer || m_eng || m_wait));
            check("m_timeout", 32'(timeout), 32'(exp_to));
            check("m_q_level", 32'(q_level), 32'(m_q.size()));
            check("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
            if (m_offer) check("m_mv_dir", 32'(mv_dir), 32'(m_dir));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        dir_req     = 4'd0;
        game_over   = 1'b0;
        frame_start = 1'b0;
        mv_ready    = 1'b0;
        eng_done    = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mv_valid"}, 32'(mv_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_q_level"}, 32'(q_level), 0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
        check({tag, "_mv_dir"}, 32'(mv_dir), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ovf_seq [6];
        logic [3:0] fill_seq [4];
        ovf_seq  = '{4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        fill_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        mid();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

`ifdef MOVE_SCHED_FRAME_SYNC_EN
        // Press, a frame pulse coinciding with IDLE->WAIT_FRAME (ignored), then the real one.
        apply_reset();
        dir_req = 4'b0100;
        tick();
        dir_req = 4'b0000;
        frame_start = 1'b1;
        mid();
        check("fs_idle_busy", 32'(busy), 0);
        tick();
        frame_start = 1'b0;
        mid();
        check("fs_wait_busy", 32'(busy), 1);
        check("fs_wait_valid", 32'(mv_valid), 0);
        next_cycles(9);
        frame_start = 1'b1;
        mid();
        check("fs_pulse_valid", 32'(mv_valid), 0);
        tick();
        frame_start = 1'b0;
        mid();
        check("fs_issue_valid", 32'(mv_valid), 1);
        check("fs_issue_dir", 32'(mv_dir), 2);
        mv_ready = 1'b1;
        tick();
        mv_ready = 1'b0;
        mid();
        check("fs_busy", 32'(busy), 1);
        reset = 1'b0;
        tick();
        mid();
        check_all_zero("fs_rst");
        reset = 1'b1;
`else
        // Single press: queued the next cycle, offered the one after.
        apply_reset();
        mv_ready = 1'b1;
        dir_req  = 4'b0100;
        tick();
        dir_req = 4'b0000;
        mid();
        check("single_qlevel", 32'(q_level), 1);
        check("single_valid_early", 32'(mv_valid), 0);
        tick();
        mid();
        check("single_valid", 32'(mv_valid), 1);
        check("single_dir", 32'(mv_dir), 2);
        check("single_busy", 32'(busy), 1);
        tick();
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        mid();
        check("single_done_busy", 32'(busy), 0);

        // Two bits at once: down wins, right is dropped.
        apply_reset();
        dir_req = 4'b1010;
        tick();
        dir_req = 4'b0000;
        mid();
        check("simul_qlevel", 32'(q_level), 1);
        check("simul_drop", 32'(drop_cnt), 1);
        tick();
        mid();
        check("simul_dir", 32'(mv_dir), 1);

        // Overflow: six presses into a depth-4 queue with the engine not accepting.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            dir_req = ovf_seq[i];
            tick();
        end
        dir_req = 4'b0000;
        mid();
        check("ovf_qlevel", 32'(q_level), 4);
        check("ovf_drop", 32'(drop_cnt), 2);
        check("ovf_valid", 32'(mv_valid), 1);
        check("ovf_dir", 32'(mv_dir), 3);
        next_cycles(2);
        mid();
        check("ovf_dir_held", 32'(mv_dir), 3);

        // Timeout: accepted move never completes.
        tick();
        mv_ready = 1'b1;
        tick();
        mv_ready = 1'b0;
        mid();
        check("to_busy", 32'(busy), 1);
        check("to_qlevel", 32'(q_level), 3);
        next_cycles(14);
        mid();
        check("to_not_yet", 32'(timeout), 0);
        tick();
        mid();
        check("to_pulse", 32'(timeout), 1);
        tick();
        mid();
        check("to_pulse_end", 32'(timeout), 0);
        check("to_idle", 32'(busy), 0);
        tick();
        mid();
        check("to_next_valid", 32'(mv_valid), 1);
        check("to_next_dir", 32'(mv_dir), 0);

        // game_over while offering with three queued.
        tick();
        game_over = 1'b1;
        dir_req   = 4'b0001;
        tick();
        dir_req = 4'b0010;
        mid();
        check("go_qlevel", 32'(q_level), 0);
        check("go_valid_held", 32'(mv_valid), 1);
        check("go_dir_held", 32'(mv_dir), 0);
        tick();
        dir_req  = 4'b0000;
        mv_ready = 1'b1;
        tick();
        mv_ready = 1'b0;
        eng_done = 1'b1;
        mid();
        check("go_busy", 32'(busy), 1);
        tick();
        eng_done = 1'b0;
        dir_req  = 4'b0100;
        mid();
        check("go_idle", 32'(busy), 0);
        tick();
        dir_req = 4'b0000;
        mid();
        check("go_no_issue", 32'(mv_valid), 0);
        check("go_drop", 32'(drop_cnt), 2);
        game_over = 1'b0;

        // Full queue with a pop in the same cycle still drops the push.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            dir_req = fill_seq[i];
            tick();
        end
        dir_req  = 4'b0001;
        mv_ready = 1'b1;
        tick();
        dir_req  = 4'b0000;
        mv_ready = 1'b0;
        mid();
        check("fullpop_qlevel", 32'(q_level), 3);
        check("fullpop_drop", 32'(drop_cnt), 1);
        // eng_done on the last timer cycle wins over the timeout.
        next_cycles(15);
        eng_done = 1'b1;
        mid();
        check("prio_timeout", 32'(timeout), 0);
        tick();
        eng_done = 1'b0;
        mid();
        check("prio_idle", 32'(busy), 0);
        tick();
        mid();
        check("prio_next_dir", 32'(mv_dir), 1);
        mv_ready = 1'b1;
        dir_req  = 4'b0100;
        tick();
        mv_ready = 1'b0;
        dir_req  = 4'b0000;
        mid();
        check("pushpop_qlevel", 32'(q_level), 3);
        // Reset on what would be the timeout cycle.
        next_cycles(15);
        reset = 1'b0;
        mid();
        check("rst_busy_to", 32'(timeout), 0);
        check("rst_busy_busy", 32'(busy), 1);
        tick();
        mid();
        check_all_zero("rst_busy");
        reset = 1'b1;
`endif

        // Mixed traffic, checked by the model alone.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            dir_req     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            if ($urandom_range(0, 40) == 0) game_over = !game_over;
            mv_ready    = ($urandom_range(0, 2) == 0);
            eng_done    = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            reset       = ($urandom_range(0, 199) != 0);
            tick();
        end
        clear_inputs();
        reset = 1'b1;
        next_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
